// File: rtl/game_input_ctrl.sv
// game_input_ctrl: front-end conditioner for the random-number game.
// Three raw push-buttons are synchronized, debounced and turned into
// single-cycle press pulses (start, P1_in, P2_in).
// A free-running 8-bit Fibonacci LFSR supplies the pseudo-random bus.
// "rand" is a reserved word in SystemVerilog, so that bus is named rand_num.
module game_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter logic [7:0]  LFSR_SEED       = 8'h01
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_start,
  input  logic       btn_p1,
  input  logic       btn_p2,
  output logic       start,
  output logic       P1_in,
  output logic       P2_in,
  output logic [7:0] rand_num
);

  localparam int unsigned      NCH      = 3;
  // A zero seed would lock the LFSR, so it is replaced by 8'h01.
  localparam logic [7:0]       SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  // Feedback taps for x^8+x^6+x^5+x^4+1 (maximal length, period 255).
  function automatic logic lfsr_fb(input logic [7:0] state);
    return state[7] ^ state[5] ^ state[4] ^ state[3];
  endfunction

  // Channel order: 0 = start, 1 = player 1, 2 = player 2.
  logic [NCH-1:0]   btn_s;
  logic [NCH-1:0]   s1_r;
  logic [NCH-1:0]   s2_r;
  logic [NCH-1:0]   stb_r;
  logic [NCH-1:0]   pulse_r;
  logic [CNT_W-1:0] cnt_r [NCH];
  logic [7:0]       lfsr_r;

  assign btn_s = {btn_p2, btn_p1, btn_start};

  // Per-channel synchronizer, debounce counter and press-pulse generation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_r    <= 3'b000;
      s2_r    <= 3'b000;
      stb_r   <= 3'b000;
      pulse_r <= 3'b000;
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      s1_r <= btn_s;
      s2_r <= s1_r;
      for (int unsigned i = 0; i < NCH; i++) begin
        // Pulse is cleared every cycle unless a rising level is accepted.
        pulse_r[i] <= 1'b0;
        if (s2_r[i] == stb_r[i]) begin
          // Level agrees with the stable value: any partial count is a glitch.
          cnt_r[i] <= CNT_ZERO;
        end else if (cnt_r[i] == CNT_MAX) begin
          // Level has differed long enough: accept it; only presses pulse.
          stb_r[i]   <= s2_r[i];
          cnt_r[i]   <= CNT_ZERO;
          pulse_r[i] <= s2_r[i];
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  // Free-running LFSR, advancing every cycle from the seed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_r <= SEED_EFF;
    end else begin
      lfsr_r <= {lfsr_r[6:0], lfsr_fb(lfsr_r)};
    end
  end

  assign start    = pulse_r[0];
  assign P1_in    = pulse_r[1];
  assign P2_in    = pulse_r[2];
  assign rand_num = lfsr_r;

endmodule

// File: doc/game_input_ctrl.md
# game_input_ctrl

Front-end input conditioner for the random-number game, driving the input side of `game_fsm`. It takes three raw, bouncing, asynchronous push-buttons and produces clean single-cycle `start`, `P1_in` and `P2_in` pulses. It also produces the free-running 8-bit pseudo-random `rand` bus that `game_fsm` samples. It sits between the board button pins and `game_fsm`, in the same clock domain.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive cycles a synchronized button level must differ from its stable level before it is accepted. Must be ≥ 1.
- `CNT_W`, default 20: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES − 1.
- `LFSR_SEED`, default 8'h01: LFSR reset value. A value of 0 is illegal; if 0 is given, the block uses 8'h01.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `btn_start`  in  1  raw start button, active-high, asynchronous to `clk`.
- `btn_p1`  in  1  raw player-1 button, active-high, asynchronous.
- `btn_p2`  in  1  raw player-2 button, active-high, asynchronous.
- `start`  out  1  one-cycle pulse on an accepted press of `btn_start`.
- `P1_in`  out  1  one-cycle pulse on an accepted press of `btn_p1`.
- `P2_in`  out  1  one-cycle pulse on an accepted press of `btn_p2`.
- `rand`  out  8  current LFSR state.

## Operation
- Three identical, independent button channels. Each channel contains:
  - a 2-FF synchronizer (`s1` → `s2`);
  - a stable-level register `stb`;
  - a debounce counter `cnt[CNT_W-1:0]`;
  - a registered output pulse.
- Channel behaviour on each clock edge:
  - If `s2 == stb`: `cnt` <= 0.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stb` <= `s2` and `cnt` <= 0. The pulse register is set to 1 on this edge only when `s2 == 1` (rising acceptance).
  - Else: `cnt` <= `cnt + 1`.
  - The pulse register is 0 on every other edge.
- A release is debounced in the same way but never produces a pulse.
- A button held high produces exactly one pulse; the next pulse requires an accepted release followed by an accepted press.
- Channels are fully independent. Simultaneous accepted presses produce simultaneous pulses. There is no priority or arbitration; turn filtering is `game_fsm`'s job.
- LFSR: Fibonacci form, polynomial x^8+x^6+x^5+x^4+1 (maximal length, period 255).
  - Feedback `fb = rand[7]^rand[5]^rand[4]^rand[3]`.
  - Update every cycle: `rand` <= {`rand[6:0]`, `fb`}.
  - The LFSR free-runs regardless of button activity and never reaches 8'h00.

## Timing
- Reset values (asynchronous, while `reset_n`=0):
  - `s1`, `s2`, `stb` = 0; `cnt` = 0;
  - `start`, `P1_in`, `P2_in` = 0;
  - `rand` = `LFSR_SEED`.
- Press latency, with D = `DEBOUNCE_CYCLES`:
  - Raw level first sampled high at edge 0.
  - `s2` = 1 after edge 1.
  - `cnt` counts on edges 2 .. D.
  - `stb` and the pulse are set at edge D+1.
  - The pulse is high for exactly the one cycle between edge D+1 and edge D+2.
- Glitch rejection: any return of `s2` to `stb` before acceptance clears `cnt`. A high excursion of `s2` lasting ≤ D−1 cycles produces no pulse.
- Button held through reset release: `stb` restarts at 0, so one pulse is emitted D+2 edges after `reset_n` rises. This is the required behaviour.
- Reset asserted mid-count: all channel state and pulses clear immediately, with no partial pulse. The LFSR returns to the seed.
- The first `rand` change occurs at the first clock edge after reset release.

## Test plan
- LFSR sequence: `LFSR_SEED`=8'h01, reset released → `rand` = 01, 02, 04, 08, 11, 23 on successive cycles. Over 255 cycles `rand` returns to 01 and never equals 00.
- Clean press: D=4, `btn_p1` held high from edge 0 → `P1_in` = 1 only between edges 5 and 6. No second pulse while held. No pulse on release.
- Bounce rejection: D=4, `btn_start` toggles 1,0,1,0 each cycle, then holds 1 → no `start` pulse during toggling. Exactly one pulse 5 edges after the final rising sample.
- Simultaneous press: D=4, `btn_p1` and `btn_p2` rise on the same cycle → `P1_in` and `P2_in` both pulse in the same single cycle; `start` stays 0.
- Reset mid-debounce: D=8, `btn_p2` high, `reset_n` pulled low at `cnt`=5 → `P2_in` stays 0 and `rand` = seed. With the button still held, one `P2_in` pulse occurs 10 edges after `reset_n` rises.
- Re-press: D=4, press accepted, release held 6 cycles, press again → exactly two `P1_in` pulses in total.
